// File: rtl/key_schedule_engine.sv
// key_schedule_engine
//   Expands a PRESENT-family master key (80 or 128 bits) into ROUNDS 64-bit
//   round keys, stores them in an internal buffer and streams them out over a
//   valid/ready handshake. Keys are sent in ascending order for encryption or
//   descending order for decryption. A buffered schedule can be replayed
//   without expanding it again.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-low reset
//   start     in   job request, sampled only while idle
//   key       in   master key, captured when start is accepted
//   decrypt   in   0 = emit 1..ROUNDS, 1 = emit ROUNDS..1 (captured on start)
//   reuse     in   replay the stored buffer if it holds a complete schedule
//   busy      out  high from the cycle after start until the done cycle
//   rk        out  round key (held at its last value when not valid)
//   rk_index  out  1-based index of rk, 0 whenever rk_valid is low
//   rk_valid  out  output handshake valid
//   rk_ready  in   output handshake ready
//   done      out  one-cycle pulse after the final beat transfers
module key_schedule_engine #(
  parameter int KEY_W  = 80,
  parameter int ROUNDS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  input  logic             decrypt,
  input  logic             reuse,
  output logic             busy,
  output logic [63:0]      rk,
  output logic [5:0]       rk_index,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic             done
);

  localparam int         AW   = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [5:0] LAST = 6'(ROUNDS);

  typedef enum logic [1:0] {IDLE, EXPAND, EMIT, DONE} state_t;

  state_t           state_q, state_d;
  logic [KEY_W-1:0] kreg_q, kreg_d;
  logic [KEY_W-1:0] kreg_rot, kreg_upd;
  logic [5:0]       i_q, i_d;
  logic [5:0]       ptr_q, ptr_d;
  logic [5:0]       rk_index_q, rk_index_d;
  logic             buf_ok_q, buf_ok_d;
  logic             dec_q, dec_d;
  logic [63:0]      rk_q, rk_d;
  logic             buf_we;
  logic [63:0]      key_buf_q [0:ROUNDS-1];

  logic [5:0]       first_ptr_in, first_ptr_q, next_ptr, last_ptr;
  logic [63:0]      rd_first_in, rd_next;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Round keys are numbered from 1; the buffer is addressed from 0.
  function automatic logic [AW-1:0] slot(input logic [5:0] p);
    return AW'(p - 6'd1);
  endfunction

  assign kreg_rot = {kreg_q[KEY_W-62:0], kreg_q[KEY_W-1:KEY_W-61]};

  // Non-linear and round-counter mixing after the 61-bit rotation.
  if (KEY_W == 128) begin : g_upd128
    always_comb begin
      kreg_upd = {sbox(kreg_rot[127:124]), sbox(kreg_rot[123:120]),
                  kreg_rot[119:67], kreg_rot[66:62] ^ i_q[4:0],
                  kreg_rot[61:0]};
    end
  end else begin : g_upd80
    always_comb begin
      kreg_upd = {sbox(kreg_rot[79:76]), kreg_rot[75:20],
                  kreg_rot[19:15] ^ i_q[4:0], kreg_rot[14:0]};
    end
  end

  // Pointer arithmetic and buffer read ports used when loading the output
  // register: the first key of a replay, and the key after the current one.
  always_comb begin
    first_ptr_in = decrypt ? LAST : 6'd1;
    first_ptr_q  = dec_q ? LAST : 6'd1;
    next_ptr     = dec_q ? ptr_q - 6'd1 : ptr_q + 6'd1;
    last_ptr     = dec_q ? 6'd1 : LAST;
    rd_first_in  = key_buf_q[slot(first_ptr_in)];
    rd_next      = key_buf_q[slot(next_ptr)];
  end

  always_comb begin
    state_d    = state_q;
    kreg_d     = kreg_q;
    i_d        = i_q;
    ptr_d      = ptr_q;
    rk_index_d = rk_index_q;
    buf_ok_d   = buf_ok_q;
    dec_d      = dec_q;
    rk_d       = rk_q;
    buf_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          dec_d = decrypt;
          if (reuse && buf_ok_q) begin
            state_d    = EMIT;
            ptr_d      = first_ptr_in;
            rk_index_d = first_ptr_in;
            rk_d       = rd_first_in;
          end else begin
            state_d  = EXPAND;
            kreg_d   = key;
            i_d      = 6'd1;
            buf_ok_d = 1'b0;
          end
        end
      end

      EXPAND: begin
        buf_we = 1'b1;
        kreg_d = kreg_upd;
        i_d    = i_q + 6'd1;
        if (i_q == LAST) begin
          // The last key is being written this cycle, so a decrypt run takes
          // its first key straight from the key register.
          state_d    = EMIT;
          buf_ok_d   = 1'b1;
          ptr_d      = first_ptr_q;
          rk_index_d = first_ptr_q;
          rk_d       = dec_q ? kreg_q[KEY_W-1 -: 64] : key_buf_q[0];
        end
      end

      EMIT: begin
        if (rk_ready) begin
          if (ptr_q == last_ptr) begin
            state_d    = DONE;
            rk_index_d = 6'd0;
          end else begin
            ptr_d      = next_ptr;
            rk_index_d = next_ptr;
            rk_d       = rd_next;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      kreg_q     <= '0;
      i_q        <= '0;
      ptr_q      <= '0;
      rk_index_q <= '0;
      buf_ok_q   <= 1'b0;
      dec_q      <= 1'b0;
      rk_q       <= '0;
    end else begin
      state_q    <= state_d;
      kreg_q     <= kreg_d;
      i_q        <= i_d;
      ptr_q      <= ptr_d;
      rk_index_q <= rk_index_d;
      buf_ok_q   <= buf_ok_d;
      dec_q      <= dec_d;
      rk_q       <= rk_d;
    end
  end

  // Buffer storage is not reset; buf_ok_q alone says whether it is usable.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      key_buf_q[slot(i_q)] <= kreg_q[KEY_W-1 -: 64];
    end
  end

  assign busy     = (state_q == EXPAND) || (state_q == EMIT);
  assign rk_valid = (state_q == EMIT);
  assign done     = (state_q == DONE);
  assign rk       = rk_q;
  assign rk_index = rk_index_q;

endmodule

// File: tb/tb_key_schedule_engine.sv
// tb_key_schedule_engine
//   Directed bench for key_schedule_engine: an 80-bit instance exercises
//   ordering, replay, backpressure and control corners; a 128-bit instance
//   checks the wide key update.
module tb_key_schedule_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start, decrypt, reuse, rk_ready;
  logic [79:0] key;
  logic        busy, rk_valid, done;
  logic [63:0] rk;
  logic [5:0]  rk_index;

  logic         start_w, rk_ready_w;
  logic [127:0] key_w;
  logic         busy_w, rk_valid_w, done_w;
  logic [63:0]  rk_w;
  logic [5:0]   rk_index_w;

  key_schedule_engine #(.KEY_W(80), .ROUNDS(32)) dut (
    .clk(clk), .reset(reset), .start(start), .key(key), .decrypt(decrypt),
    .reuse(reuse), .busy(busy), .rk(rk), .rk_index(rk_index),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .done(done)
  );

  key_schedule_engine #(.KEY_W(128), .ROUNDS(32)) dut_w (
    .clk(clk), .reset(reset), .start(start_w), .key(key_w), .decrypt(1'b0),
    .reuse(1'b0), .busy(busy_w), .rk(rk_w), .rk_index(rk_index_w),
    .rk_valid(rk_valid_w), .rk_ready(rk_ready_w), .done(done_w)
  );

  localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0,
                                       4'hA, 4'hD, 4'h3, 4'hE, 4'hF, 4'h8,
                                       4'h4, 4'h7, 4'h1, 4'h2};

  localparam logic [79:0] K_A = 80'hFEDCBA98765432100F0F;
  localparam logic [79:0] K_B = 80'h13579BDF02468ACE1234;
  localparam logic [79:0] K_C = 80'hA5A5A5A5A5A5A5A5A5A5;
  localparam logic [79:0] K_P = 80'h0123456789ABCDEF0123;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_rk  [1:32];
  logic [63:0] zero_rk [1:32];
  logic [63:0] exp_w   [1:32];

  logic [5:0]  beat_idx [$];
  logic [63:0] beat_rk  [$];
  int          stall_changes, bubbles;
  logic        done_after, busy_after, valid_after;
  logic [5:0]  idx_after;
  logic [63:0] rk_after;
  logic        busy_t1;

  task automatic model80(input logic [79:0] k0);
    logic [79:0] k;
    k = k0;
    for (int r = 1; r <= 32; r++) begin
      logic [4:0] rc;
      rc = 5'(r);
      exp_rk[r] = k[79:16];
      k = (k << 61) | (k >> 19);
      k[79:76] = SBOX[k[79:76]];
      k[19:15] = k[19:15] ^ rc;
    end
  endtask

  task automatic model128(input logic [127:0] k0);
    logic [127:0] k;
    k = k0;
    for (int r = 1; r <= 32; r++) begin
      logic [4:0] rc;
      rc = 5'(r);
      exp_w[r] = k[127:64];
      k = (k << 61) | (k >> 67);
      k[127:124] = SBOX[k[127:124]];
      k[123:120] = SBOX[k[123:120]];
      k[66:62]   = k[66:62] ^ rc;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one start and waits for the first valid beat; lat counts clock
  // edges from the accepting edge up to the first valid cycle.
  task automatic start_job(input logic [79:0] k, input logic dec,
                           input logic ru, output int lat);
    key = k; decrypt = dec; reuse = ru; start = 1'b1;
    step();
    busy_t1 = busy;
    start = 1'b0; key = ~k; decrypt = ~dec; reuse = 1'b0;
    lat = 1;
    while (!rk_valid && lat < 100) begin
      step();
      lat++;
    end
  endtask

  // Drains 32 beats, recording each transfer and any change while stalled.
  task automatic collect(input bit bp);
    int guard;
    bit stalled;
    logic [63:0] hold_rk;
    logic [5:0]  hold_idx;
    beat_idx.delete();
    beat_rk.delete();
    stall_changes = 0; bubbles = 0; stalled = 0; guard = 0;
    hold_rk = '0; hold_idx = '0;
    while (beat_idx.size() < 32 && guard < 2000) begin
      rk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rk_valid) begin
        if (stalled && (rk !== hold_rk || rk_index !== hold_idx)) stall_changes++;
        if (rk_ready) begin
          beat_idx.push_back(rk_index);
          beat_rk.push_back(rk);
          stalled = 0;
        end else begin
          stalled = 1; hold_rk = rk; hold_idx = rk_index;
        end
      end else if (beat_idx.size() > 0) begin
        bubbles++;
      end
      step();
      guard++;
    end
    rk_ready    = 1'b1;
    done_after  = done;
    busy_after  = busy;
    valid_after = rk_valid;
    idx_after   = rk_index;
    rk_after    = rk;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    checks++;
    if ({busy, rk_valid, done, rk_index, rk} !== 73'd0) begin
      errors++;
      $display("[TB] FAIL reset80: got busy=%b valid=%b done=%b idx=%0d rk=%h, want all 0",
               busy, rk_valid, done, rk_index, rk);
    end
    checks++;
    if ({busy_w, rk_valid_w, done_w, rk_index_w, rk_w} !== 73'd0) begin
      errors++;
      $display("[TB] FAIL reset128: got busy=%b valid=%b done=%b idx=%0d rk=%h, want all 0",
               busy_w, rk_valid_w, done_w, rk_index_w, rk_w);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_encrypt_zero();
    int lat;
    model80('0);
    for (int r = 1; r <= 32; r++) zero_rk[r] = exp_rk[r];
    start_job('0, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 33) begin
      errors++; $display("[TB] FAIL enc_latency: got %0d want 33", lat);
    end
    checks++;
    if (busy_t1 !== 1'b1) begin
      errors++; $display("[TB] FAIL enc_busy: got %b want 1", busy_t1);
    end
    collect(1'b0);
    checks++;
    if (beat_idx.size() !== 32) begin
      errors++; $display("[TB] FAIL enc_count: got %0d want 32", beat_idx.size());
    end
    for (int n = 0; n < beat_idx.size(); n++) begin
      checks++;
      if (beat_idx[n] !== 6'(n + 1) || beat_rk[n] !== zero_rk[n + 1]) begin
        errors++;
        $display("[TB] FAIL enc_beat%0d: got idx=%0d rk=%h want idx=%0d rk=%h",
                 n, beat_idx[n], beat_rk[n], n + 1, zero_rk[n + 1]);
      end
    end
    if (beat_rk.size() >= 3) begin
      checks++;
      if (beat_rk[0] !== 64'h0 || beat_rk[1] !== 64'hC000000000000000 ||
          beat_rk[2] !== 64'h5000180000000001) begin
        errors++;
        $display("[TB] FAIL enc_vectors: got %h %h %h want 0 c000000000000000 5000180000000001",
                 beat_rk[0], beat_rk[1], beat_rk[2]);
      end
    end
    checks++;
    if (bubbles !== 0) begin
      errors++; $display("[TB] FAIL enc_bubbles: got %0d want 0", bubbles);
    end
    checks++;
    if ({done_after, busy_after, valid_after, idx_after} !== {1'b1, 1'b0, 1'b0, 6'd0}) begin
      errors++;
      $display("[TB] FAIL enc_done: got done=%b busy=%b valid=%b idx=%0d want 1 0 0 0",
               done_after, busy_after, valid_after, idx_after);
    end
    checks++;
    if (rk_after !== zero_rk[32]) begin
      errors++; $display("[TB] FAIL enc_rk_hold: got %h want %h", rk_after, zero_rk[32]);
    end
    step();
  endtask

  task automatic test_decrypt_zero();
    int lat;
    start_job('0, 1'b1, 1'b0, lat);
    checks++;
    if (lat !== 33) begin
      errors++; $display("[TB] FAIL dec_latency: got %0d want 33", lat);
    end
    collect(1'b0);
    checks++;
    if (beat_idx.size() !== 32) begin
      errors++; $display("[TB] FAIL dec_count: got %0d want 32", beat_idx.size());
    end
    for (int n = 0; n < beat_idx.size(); n++) begin
      checks++;
      if (beat_idx[n] !== 6'(32 - n) || beat_rk[n] !== zero_rk[32 - n]) begin
        errors++;
        $display("[TB] FAIL dec_beat%0d: got idx=%0d rk=%h want idx=%0d rk=%h",
                 n, beat_idx[n], beat_rk[n], 32 - n, zero_rk[32 - n]);
      end
    end
    if (beat_rk.size() == 32) begin
      checks++;
      if (beat_idx[31] !== 6'd1 || beat_rk[31] !== 64'h0) begin
        errors++;
        $display("[TB] FAIL dec_last: got idx=%0d rk=%h want idx=1 rk=0", beat_idx[31], beat_rk[31]);
      end
    end
    checks++;
    if (done_after !== 1'b1) begin
      errors++; $display("[TB] FAIL dec_done: got %b want 1", done_after);
    end
    step();
  endtask

  task automatic test_reuse();
    int lat;
    start_job('1, 1'b1, 1'b1, lat);
    checks++;
    if (lat !== 1) begin
      errors++; $display("[TB] FAIL reuse_latency: got %0d want 1", lat);
    end
    collect(1'b0);
    checks++;
    if (beat_idx.size() !== 32) begin
      errors++; $display("[TB] FAIL reuse_count: got %0d want 32", beat_idx.size());
    end
    for (int n = 0; n < beat_idx.size(); n++) begin
      checks++;
      if (beat_idx[n] !== 6'(32 - n) || beat_rk[n] !== zero_rk[32 - n]) begin
        errors++;
        $display("[TB] FAIL reuse_beat%0d: got idx=%0d rk=%h want idx=%0d rk=%h",
                 n, beat_idx[n], beat_rk[n], 32 - n, zero_rk[32 - n]);
      end
    end
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    model80('1);
    start_job('1, 1'b1, 1'b1, lat);
    checks++;
    if (lat !== 33) begin
      errors++; $display("[TB] FAIL reuse_after_reset_latency: got %0d want 33", lat);
    end
    collect(1'b0);
    checks++;
    if (beat_idx.size() !== 32) begin
      errors++; $display("[TB] FAIL reuse_after_reset_count: got %0d want 32", beat_idx.size());
    end
    for (int n = 0; n < beat_idx.size(); n++) begin
      checks++;
      if (beat_idx[n] !== 6'(32 - n) || beat_rk[n] !== exp_rk[32 - n]) begin
        errors++;
        $display("[TB] FAIL ones_beat%0d: got idx=%0d rk=%h want idx=%0d rk=%h",
                 n, beat_idx[n], beat_rk[n], 32 - n, exp_rk[32 - n]);
      end
    end
    if (beat_rk.size() == 32) begin
      checks++;
      if (beat_rk[31] !== 64'hFFFFFFFFFFFFFFFF || beat_rk[30] !== 64'h2FFFFFFFFFFFFFFF) begin
        errors++;
        $display("[TB] FAIL ones_vectors: got %h %h want ffffffffffffffff 2fffffffffffffff",
                 beat_rk[31], beat_rk[30]);
      end
    end
    step();
  endtask

  task automatic test_backpressure();
    int lat;
    model80(K_P);
    start_job(K_P, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 33) begin
      errors++; $display("[TB] FAIL bp_latency: got %0d want 33", lat);
    end
    collect(1'b1);
    checks++;
    if (stall_changes !== 0) begin
      errors++; $display("[TB] FAIL bp_stable: got %0d changes while stalled want 0", stall_changes);
    end
    checks++;
    if (beat_idx.size() !== 32) begin
      errors++; $display("[TB] FAIL bp_count: got %0d want 32", beat_idx.size());
    end
    for (int n = 0; n < beat_idx.size(); n++) begin
      checks++;
      if (beat_idx[n] !== 6'(n + 1) || beat_rk[n] !== exp_rk[n + 1]) begin
        errors++;
        $display("[TB] FAIL bp_beat%0d: got idx=%0d rk=%h want idx=%0d rk=%h",
                 n, beat_idx[n], beat_rk[n], n + 1, exp_rk[n + 1]);
      end
    end
    step();
  endtask

  task automatic test_key128();
    int lat, n, guard;
    model128('0);
    key_w = '0; start_w = 1'b1;
    step();
    start_w = 1'b0; key_w = '1;
    lat = 1;
    while (!rk_valid_w && lat < 100) begin
      step();
      lat++;
    end
    checks++;
    if (lat !== 33) begin
      errors++; $display("[TB] FAIL w_latency: got %0d want 33", lat);
    end
    n = 0; guard = 0;
    while (n < 32 && guard < 200) begin
      if (rk_valid_w) begin
        checks++;
        if (rk_index_w !== 6'(n + 1) || rk_w !== exp_w[n + 1]) begin
          errors++;
          $display("[TB] FAIL w_beat%0d: got idx=%0d rk=%h want idx=%0d rk=%h",
                   n, rk_index_w, rk_w, n + 1, exp_w[n + 1]);
        end
        if (n == 1) begin
          checks++;
          if (rk_w !== 64'hCC00000000000000) begin
            errors++; $display("[TB] FAIL w_index2: got %h want cc00000000000000", rk_w);
          end
        end
        n++;
      end
      step();
      guard++;
    end
    checks++;
    if (n !== 32 || done_w !== 1'b1) begin
      errors++; $display("[TB] FAIL w_done: got beats=%0d done=%b want 32 1", n, done_w);
    end
    step();
  endtask

  task automatic test_start_ignored();
    int lat;
    model80(K_A);
    key = K_A; decrypt = 1'b0; reuse = 1'b0; start = 1'b1;
    step();
    key = K_B; decrypt = 1'b1; reuse = 1'b1;
    lat = 1;
    while (!rk_valid && lat < 100) begin
      step();
      lat++;
    end
    checks++;
    if (lat !== 33) begin
      errors++; $display("[TB] FAIL ign_latency: got %0d want 33", lat);
    end
    collect(1'b0);
    start = 1'b0;
    checks++;
    if (beat_idx.size() !== 32) begin
      errors++; $display("[TB] FAIL ign_count: got %0d want 32", beat_idx.size());
    end
    for (int n = 0; n < beat_idx.size(); n++) begin
      checks++;
      if (beat_idx[n] !== 6'(n + 1) || beat_rk[n] !== exp_rk[n + 1]) begin
        errors++;
        $display("[TB] FAIL ign_beat%0d: got idx=%0d rk=%h want idx=%0d rk=%h",
                 n, beat_idx[n], beat_rk[n], n + 1, exp_rk[n + 1]);
      end
    end
    step();
    checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL ign_idle: got busy=%b valid=%b want 0 0", busy, rk_valid);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    start_job(K_B, 1'b0, 1'b1, lat);
    checks++;
    if (lat !== 1) begin
      errors++; $display("[TB] FAIL b2b_latency: got %0d want 1", lat);
    end
    collect(1'b0);
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_done: got %b want 1", done);
    end
    start = 1'b1; reuse = 1'b1; decrypt = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_early_start: got busy=%b valid=%b want 0 0", busy, rk_valid);
    end
    step();
    start = 1'b0; reuse = 1'b0; decrypt = 1'b0;
    checks++;
    if (busy !== 1'b1 || rk_valid !== 1'b1 || rk_index !== 6'd32 || rk !== exp_rk[32]) begin
      errors++;
      $display("[TB] FAIL b2b_accept: got busy=%b valid=%b idx=%0d rk=%h want 1 1 32 %h",
               busy, rk_valid, rk_index, rk, exp_rk[32]);
    end
    collect(1'b0);
    checks++;
    if (beat_idx.size() !== 32) begin
      errors++; $display("[TB] FAIL b2b_count: got %0d want 32", beat_idx.size());
    end
    step();
  endtask

  task automatic test_reset_mid();
    int lat, guard;
    key = K_B; decrypt = 1'b0; reuse = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 10; c++) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    model80(K_C);
    start_job(K_C, 1'b0, 1'b1, lat);
    checks++;
    if (lat !== 33) begin
      errors++; $display("[TB] FAIL rst_expand_latency: got %0d want 33", lat);
    end
    collect(1'b0);
    checks++;
    if (beat_idx.size() !== 32) begin
      errors++; $display("[TB] FAIL rst_expand_count: got %0d want 32", beat_idx.size());
    end
    for (int n = 0; n < beat_idx.size(); n++) begin
      checks++;
      if (beat_idx[n] !== 6'(n + 1) || beat_rk[n] !== exp_rk[n + 1]) begin
        errors++;
        $display("[TB] FAIL rst_expand_beat%0d: got idx=%0d rk=%h want idx=%0d rk=%h",
                 n, beat_idx[n], beat_rk[n], n + 1, exp_rk[n + 1]);
      end
    end
    step();
    start_job(K_A, 1'b0, 1'b1, lat);
    checks++;
    if (lat !== 1) begin
      errors++; $display("[TB] FAIL rst_emit_reuse_latency: got %0d want 1", lat);
    end
    rk_ready = 1'b1;
    guard = 0;
    while (rk_index !== 6'd10 && guard < 100) begin
      step();
      guard++;
    end
    checks++;
    if (rk_index !== 6'd10 || rk !== exp_rk[10]) begin
      errors++; $display("[TB] FAIL rst_emit_reach: got idx=%0d rk=%h want 10 %h", rk_index, rk, exp_rk[10]);
    end
    reset = 1'b0;
    step();
    checks++;
    if ({busy, rk_valid, done, rk_index, rk} !== 73'd0) begin
      errors++;
      $display("[TB] FAIL rst_emit: got busy=%b valid=%b done=%b idx=%0d rk=%h want all 0",
               busy, rk_valid, done, rk_index, rk);
    end
    reset = 1'b1;
    step();
    checks++;
    if ({busy, rk_valid, done, rk_index} !== 9'd0) begin
      errors++;
      $display("[TB] FAIL rst_emit_idle: got busy=%b valid=%b done=%b idx=%0d want all 0",
               busy, rk_valid, done, rk_index);
    end
    start_job(K_A, 1'b0, 1'b1, lat);
    checks++;
    if (lat !== 33) begin
      errors++; $display("[TB] FAIL rst_emit_buf_invalid: got latency %0d want 33", lat);
    end
    collect(1'b0);
    step();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0; start = 1'b0; decrypt = 1'b0; reuse = 1'b0; rk_ready = 1'b1;
    key = '0; start_w = 1'b0; rk_ready_w = 1'b1; key_w = '0;
    test_reset();
    test_encrypt_zero();
    test_decrypt_zero();
    test_reuse();
    test_backpressure();
    test_key128();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
